lenet_result_streamer: RTL and testbench

Transmit-side counterpart of the LeNet accelerator's parallel `output_vector`. Captures the 10-element signed score vector in one handshake, streams it out one score per beat on a valid/ready interface, and reports the argmax class when the last beat is accepted. Sits between the accelerator core and the host/readout path.

---
 rtl/lenet_pkg.sv | 19 +
 rtl/lenet_argmax_tracker.sv | 36 +++
 rtl/lenet_result_streamer.sv | 116 +++++++++++
 tb/tb_lenet_result_streamer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/lenet_pkg.sv
// Shared types and sizing for the LeNet result path: score width, class count,
// score vector type and the streamer FSM encoding.
package lenet_pkg;

  localparam int BITWIDTH    = 32;
  localparam int NUM_CLASSES = 10;
  localparam int IDX_W       = $clog2(NUM_CLASSES);

  typedef logic signed [BITWIDTH-1:0] score_t;
  typedef score_t score_vec_t [NUM_CLASSES];

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } stream_state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

endpackage

// File: rtl/lenet_argmax_tracker.sv
// Running signed argmax over a stream of scores; the first beat of a frame
// loads unconditionally, later beats win only when strictly greater.
module lenet_argmax_tracker
  import lenet_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             valid,
  input  score_t           score,
  input  logic [IDX_W-1:0] idx,
  output score_t           max_score,
  output logic [IDX_W-1:0] max_idx
);

  score_t           r_max;
  logic [IDX_W-1:0] r_idx;
  logic             w_take;

  // Strict compare keeps the earliest index on ties.
  assign w_take = valid && (start || (score > r_max));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_max <= '0;
      r_idx <= '0;
    end else if (w_take) begin
      r_max <= score;
      r_idx <= idx;
    end
  end

  assign max_score = r_max;
  assign max_idx   = r_idx;

endmodule

// File: rtl/lenet_result_streamer.sv
// Captures a full score vector, streams it one score per valid/ready beat and
// publishes the argmax class one cycle after the final beat is accepted.
module lenet_result_streamer
  import lenet_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  score_t           in_vector [NUM_CLASSES],
  output logic             out_valid,
  input  logic             out_ready,
  output score_t           out_data,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             class_valid,
  output logic [IDX_W-1:0] class_idx,
  output score_t           class_score
);

  stream_state_t    r_state;
  score_t           r_buf [NUM_CLASSES];
  logic [IDX_W-1:0] r_cnt;
  logic             r_class_valid;
  logic [IDX_W-1:0] r_class_idx;
  score_t           r_class_score;

  logic             w_send;
  logic             w_capture;
  logic             w_xfer;
  logic             w_last_xfer;
  score_t           w_run_max;
  logic [IDX_W-1:0] w_run_idx;

  assign w_send      = (r_state == ST_SEND);
  assign in_ready    = (r_state == ST_IDLE) && !rst;
  assign w_capture   = in_valid && in_ready;
  assign w_xfer      = out_valid && out_ready;
  assign w_last_xfer = w_xfer && out_last;

  assign out_valid = w_send;
  assign out_index = w_send ? r_cnt : '0;
  assign out_data  = w_send ? r_buf[r_cnt] : '0;
  assign out_last  = w_send && (r_cnt == LAST_IDX);

  // Shadow buffer needs no reset: it is only observed while in SEND.
  generate
    for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_buf
      always_ff @(posedge clk) begin
        if (w_capture) begin
          r_buf[gi] <= in_vector[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_capture) begin
            r_state <= ST_SEND;
            r_cnt   <= '0;
          end
        end
        ST_SEND: begin
          if (w_last_xfer) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (w_xfer) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  lenet_argmax_tracker u_argmax (
    .clk       (clk),
    .rst       (rst),
    .start     (r_cnt == '0),
    .valid     (w_xfer),
    .score     (out_data),
    .idx       (r_cnt),
    .max_score (w_run_max),
    .max_idx   (w_run_idx)
  );

  // During the pulse the tracker already holds the final max; latch it so the
  // reported class survives the tracker being reused by the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_class_valid <= 1'b0;
      r_class_idx   <= '0;
      r_class_score <= '0;
    end else begin
      r_class_valid <= w_last_xfer;
      if (r_class_valid) begin
        r_class_idx   <= w_run_idx;
        r_class_score <= w_run_max;
      end
    end
  end

  assign class_valid = r_class_valid;
  assign class_idx   = r_class_valid ? w_run_idx : r_class_idx;
  assign class_score = r_class_valid ? w_run_max : r_class_score;

endmodule

// File: tb/tb_lenet_result_streamer.sv
// Directed bench for lenet_result_streamer: scoreboard of expected beats and
// argmax results, checked by a negedge monitor.
module tb_lenet_result_streamer;
  import lenet_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  score_t           in_vector [NUM_CLASSES];
  logic             out_valid;
  logic             out_ready = 1'b0;
  score_t           out_data;
  logic [IDX_W-1:0] out_index;
  logic             out_last;
  logic             class_valid;
  logic [IDX_W-1:0] class_idx;
  score_t           class_score;

  typedef struct packed {
    score_t           score;
    logic [IDX_W-1:0] idx;
  } exp_t;

  exp_t   beat_q [$];
  exp_t   class_q [$];
  score_t stim_vec [NUM_CLASSES];
  int     tests = 0;
  int     fails = 0;
  logic   prev_cv = 1'b0;

  always #5 clk = ~clk;

  lenet_result_streamer dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_vector   (in_vector),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_index   (out_index),
    .out_last    (out_last),
    .class_valid (class_valid),
    .class_idx   (class_idx),
    .class_score (class_score)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: every presented beat must match the scoreboard head (so stalled
  // beats are checked to hold), accepted beats pop it.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        check("beat_expected", 64'(beat_q.size() != 0), 64'd1);
        if (beat_q.size() != 0) begin
          check("beat_data", out_data, beat_q[0].score);
          check("beat_index", out_index, beat_q[0].idx);
          check("beat_last", out_last, beat_q[0].idx == LAST_IDX);
          if (out_ready) begin
            $display("[TB] beat idx=%0d data=%0d last=%0b", out_index, out_data, out_last);
            void'(beat_q.pop_front());
          end
        end
      end
      if (class_valid) begin
        check("class_pulse_single", prev_cv, 1'b0);
        check("class_expected", 64'(class_q.size() != 0), 64'd1);
        if (class_q.size() != 0) begin
          check("class_idx", class_idx, class_q[0].idx);
          check("class_score", class_score, class_q[0].score);
          $display("[TB] class idx=%0d score=%0d", class_idx, class_score);
          void'(class_q.pop_front());
        end
      end
    end
    prev_cv = class_valid;
  end

  // mode 0: ready held high, 1: ready pattern 1,0,0,..., 2: in_vector/in_valid
  // disturbed mid-frame, 3: reset after beat 4.
  task automatic run_frame(input int mode);
    int               cycles;
    int               stalls;
    int               k;
    bit               done;
    score_t           mx;
    logic [IDX_W-1:0] mi;
    k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("in_ready_before_capture", in_ready, 1'b1);
    in_vector = stim_vec;
    in_valid  = 1'b1;
    mx = stim_vec[0];
    mi = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      beat_q.push_back('{score: stim_vec[i], idx: IDX_W'(i)});
      if (i > 0 && stim_vec[i] > mx) begin
        mx = stim_vec[i];
        mi = IDX_W'(i);
      end
    end
    if (mode != 3) class_q.push_back('{score: mx, idx: mi});
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycles = 0;
    stalls = 0;
    done   = 1'b0;
    while (!done && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (class_valid) begin
        done = 1'b1;
        check("in_ready_at_class_valid", in_ready, 1'b1);
      end else if (mode == 3 && cycles == 5) begin
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("in_ready_in_reset", in_ready, 1'b0);
        beat_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_out_index", out_index, '0);
        check("abort_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 12; i++) begin
          check("abort_no_class", class_valid, 1'b0);
          @(negedge clk);
        end
        done = 1'b1;
      end else begin
        if (out_valid && !out_ready) stalls++;
        if (mode == 2 && cycles == 3) check("in_ready_in_send", in_ready, 1'b0);
        @(posedge clk); #1;
        out_ready = (mode == 1) ? ((cycles % 3) == 0) : 1'b1;
        if (mode == 2) begin
          if (cycles == 2) begin
            for (int i = 0; i < NUM_CLASSES; i++) in_vector[i] = score_t'(1000 - 7 * i);
            in_valid = 1'b1;
          end else begin
            in_valid = 1'b0;
          end
        end
      end
    end
    if (mode != 3) begin
      check("frame_done", done, 1'b1);
      check("frame_cycles", cycles, 11 + stalls);
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_CLASSES; i++) in_vector[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_data", out_data, '0);
    check("rst_out_index", out_index, '0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_class_valid", class_valid, 1'b0);
    check("rst_class_idx", class_idx, '0);
    check("rst_class_score", class_score, '0);
    check("idle_in_ready", in_ready, 1'b1);

    for (int i = 0; i < NUM_CLASSES; i++) stim_vec[i] = score_t'(i);
    run_frame(0);

    for (int i = 0; i < NUM_CLASSES; i++) stim_vec[i] = -32'sd5;
    stim_vec[3] = 32'sd50;
    stim_vec[7] = 32'sd50;
    run_frame(0);

    stim_vec = '{-32'sd10, -32'sd3, -32'sd8, -32'sd20, -32'sd15,
                 -32'sd9, -32'sd7, -32'sd30, -32'sd4, -32'sd11};
    run_frame(0);

    stim_vec = '{32'sd7, -32'sd2, 32'sd100, 32'sd33, 32'sd100,
                 -32'sd50, 32'sd0, 32'sd99, -32'sd1, 32'sd5};
    run_frame(1);

    for (int i = 0; i < NUM_CLASSES; i++) stim_vec[i] = score_t'(i + 1);
    run_frame(2);

    for (int i = 0; i < NUM_CLASSES; i++) stim_vec[i] = score_t'(3 * i);
    run_frame(3);

    for (int i = 0; i < NUM_CLASSES; i++) stim_vec[i] = score_t'(9 - i);
    run_frame(0);

    repeat (3) @(negedge clk);
    check("beat_q_drained", beat_q.size(), 0);
    check("class_q_drained", class_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
